// File: rtl/pkg_config.sv
// pkg_config: shared datapath configuration for the core pipeline.
package pkg_config;
   parameter int DATA_WIDTH = 32;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one word fetch at a time and presents it to decode,
// squashing wrong-path responses (including in-flight ones) on redirect.
module fetch_unit
   import pkg_config::*;
#(
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]           NOP_INSTR = 32'h0000_0013
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_target_i,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [31:0]           imem_rdata_i,
   output logic                  if_valid_o,
   input  logic                  if_ready_i,
   output logic [DATA_WIDTH-1:0] if_pc_o,
   output logic [DATA_WIDTH-1:0] if_pc_plus4_o,
   output logic [31:0]           if_instr_o,
   output logic                  misaligned_o,
   output logic [DATA_WIDTH-1:0] misaligned_addr_o
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, if_pc_q, if_pc_d, if_pc4_q, if_pc4_d, mis_addr_q, mis_addr_d;
   logic [31:0]           if_instr_q, if_instr_d;
   logic                  kill_q, kill_d, stall_q, stall_d, if_valid_q, if_valid_d, mis_q, mis_d;
   logic                  redir_ok, redir_bad, in_flight;

   always_comb begin
      redir_ok   = redirect_i & ~redirect_target_i[1];
      redir_bad  = redirect_i & redirect_target_i[1];
      in_flight  = (state_q == REQ && imem_gnt_i) || (state_q == WAIT && !imem_rvalid_i);
      state_d    = state_q;
      pc_d       = pc_q;
      kill_d     = kill_q;
      stall_d    = stall_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_pc4_d   = if_pc4_q;
      if_instr_d = if_instr_q;
      mis_d      = 1'b0;
      mis_addr_d = mis_addr_q;
      case (state_q)
         IDLE: state_d = stall_q ? IDLE : REQ;
         REQ:  state_d = imem_gnt_i ? WAIT : REQ;
         WAIT: begin
            if (imem_rvalid_i && kill_q) begin
               kill_d  = 1'b0;
               state_d = stall_q ? IDLE : REQ;
            end else if (imem_rvalid_i) begin
               if_instr_d = imem_rdata_i;
               if_pc_d    = pc_q;
               if_pc4_d   = pc_q + DATA_WIDTH'(4);
               if_valid_d = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (if_ready_i) begin
               if_valid_d = 1'b0;
               pc_d       = pc_q + DATA_WIDTH'(4);
               state_d    = REQ;
            end
         end
      endcase
      // A redirect overrides everything above; an outstanding request is drained under kill.
      if (redirect_i) begin
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
         kill_d     = in_flight | (kill_q & state_q == WAIT & !imem_rvalid_i);
         stall_d    = redir_bad;
         pc_d       = redir_ok ? {redirect_target_i[DATA_WIDTH-1:2], 2'b00} : pc_q;
         state_d    = in_flight ? WAIT : (redir_ok ? REQ : IDLE);
      end
      if (redir_bad) begin
         mis_d      = 1'b1;
         mis_addr_d = redirect_target_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         kill_q     <= 1'b0;
         stall_q    <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= RESET_PC;
         if_pc4_q   <= RESET_PC + DATA_WIDTH'(4);
         if_instr_q <= NOP_INSTR;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         kill_q     <= kill_d;
         stall_q    <= stall_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_pc4_q   <= if_pc4_d;
         if_instr_q <= if_instr_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   assign imem_req_o        = state_q == REQ;
   assign imem_addr_o       = pc_q;
   assign if_valid_o        = if_valid_q;
   assign if_pc_o           = if_pc_q;
   assign if_pc_plus4_o     = if_pc4_q;
   assign if_instr_o        = if_instr_q;
   assign misaligned_o      = mis_q;
   assign misaligned_addr_o = mis_addr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus against a zero/variable-wait memory, with an
// architectural PC model checked every cycle plus hand-computed literal checks.
module tb_fetch_unit;
   import pkg_config::*;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_i = 1'b0, rst_ni = 1'b0, redirect_i = 1'b0, imem_gnt_i = 1'b1;
   logic        imem_rvalid_i = 1'b0, if_ready_i = 1'b1;
   logic [31:0] redirect_target_i = '0, imem_rdata_i = '0;
   logic        imem_req_o, if_valid_o, misaligned_o;
   logic [31:0] imem_addr_o, if_pc_o, if_pc_plus4_o, if_instr_o, misaligned_addr_o;

   int          n_chk = 0, n_pass = 0, cyc = 0, rv_delay = 0;
   logic [31:0] fetch_q[$], pres_pc[$], pres_p4[$], pres_in[$];
   int          fetch_c[$];

   fetch_unit dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o),
      .if_ready_i(if_ready_i), .if_pc_o(if_pc_o), .if_pc_plus4_o(if_pc_plus4_o),
      .if_instr_o(if_instr_o), .misaligned_o(misaligned_o), .misaligned_addr_o(misaligned_addr_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a == 32'h8 ? NOP : a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_valid(input logic [31:0] pc);
      int i;
      for (i = 0; i < 60 && !(if_valid_o && if_pc_o == pc); i++) step();
      if (i == 60) chk("wait_valid", if_valid_o ? if_pc_o : 32'hDEAD_DEAD, pc);
   endtask

   task automatic wait_fetch(input logic [31:0] a);
      int i;
      for (i = 0; i < 60 && !(imem_req_o && imem_addr_o == a); i++) step();
      if (i == 60) chk("wait_fetch", imem_req_o ? imem_addr_o : 32'hDEAD_DEAD, a);
   endtask

   task automatic clear_logs();
      fetch_q.delete(); fetch_c.delete(); pres_pc.delete(); pres_p4.delete(); pres_in.delete();
   endtask

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
      return q.size() > i ? q[i] : 32'hDEAD_BEEF;
   endfunction

   // Memory: grant is immediate, response rv_delay cycles after the cycle following the grant.
   initial begin
      logic        fire, pend;
      logic [31:0] fa, paddr;
      int          cnt;
      pend = 0; cnt = 0; paddr = 0;
      forever begin
         @(negedge clk_i);
         fire = rst_ni && imem_req_o && imem_gnt_i;
         fa   = imem_addr_o;
         @(posedge clk_i);
         #1;
         imem_rvalid_i = 1'b0;
         if (fire) begin pend = 1; cnt = rv_delay; paddr = fa; end
         if (!rst_ni) pend = 0;
         if (pend) begin
            if (cnt == 0) begin imem_rvalid_i = 1'b1; imem_rdata_i = mem(paddr); pend = 0; end
            else cnt--;
         end
      end
   end

   // Architectural model: PC follows redirects and accepts; outputs must reflect it every cycle.
   initial begin
      logic [31:0] m_pc, m_mis_addr, s_pc, s_p4, s_in;
      logic        m_stall, m_mis, m_hold, m_flush;
      m_pc = 0; m_mis_addr = 0; m_stall = 0; m_mis = 0; m_hold = 0; m_flush = 0;
      s_pc = 0; s_p4 = 0; s_in = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            m_pc = 0; m_mis_addr = 0; m_stall = 0; m_mis = 0; m_hold = 0; m_flush = 0;
            chk("rst_req", imem_req_o, 0);
            chk("rst_valid", if_valid_o, 0);
            chk("rst_pc", if_pc_o, 0);
            chk("rst_instr", if_instr_o, NOP);
            chk("rst_mis_addr", misaligned_addr_o, 0);
         end else begin
            chk("mis", misaligned_o, m_mis);
            chk("mis_addr", misaligned_addr_o, m_mis_addr);
            if (imem_req_o) chk("fetch_addr", imem_addr_o, m_pc);
            if (m_stall) begin
               chk("stall_req", imem_req_o, 0);
               chk("stall_valid", if_valid_o, 0);
            end
            if (m_flush) begin
               chk("flush_valid", if_valid_o, 0);
               chk("flush_instr", if_instr_o, NOP);
            end
            if (if_valid_o) begin
               chk("pres_pc", if_pc_o, m_pc);
               chk("pres_pc4", if_pc_plus4_o, m_pc + 4);
               chk("pres_instr", if_instr_o, mem(m_pc));
            end
            if (m_hold) begin
               chk("hold_valid", if_valid_o, 1);
               chk("hold_pc", if_pc_o, s_pc);
               chk("hold_pc4", if_pc_plus4_o, s_p4);
               chk("hold_instr", if_instr_o, s_in);
            end
            if (imem_req_o && imem_gnt_i) begin fetch_q.push_back(imem_addr_o); fetch_c.push_back(cyc); end
            if (if_valid_o && !m_hold) begin
               pres_pc.push_back(if_pc_o); pres_p4.push_back(if_pc_plus4_o); pres_in.push_back(if_instr_o);
            end
            m_mis   = redirect_i && redirect_target_i[1];
            m_flush = redirect_i;
            m_hold  = if_valid_o && !if_ready_i && !redirect_i;
            s_pc = if_pc_o; s_p4 = if_pc_plus4_o; s_in = if_instr_o;
            if (m_mis) begin m_mis_addr = redirect_target_i; m_stall = 1; end
            else if (redirect_i) begin m_pc = redirect_target_i & ~32'h3; m_stall = 0; end
            else if (if_valid_o && if_ready_i) m_pc = m_pc + 4;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      clear_logs();
      chk("idle_after_release", imem_req_o, 0);
      step();
      chk("first_req", imem_req_o, 1);
      chk("first_addr", imem_addr_o, 32'h0);
      // Stall decode while holding the instruction at PC 0x8.
      wait_valid(32'h8);
      if_ready_i = 1'b0;
      repeat (5) begin
         step();
         chk("stall_hold_pc", if_pc_o, 32'h8);
         chk("stall_hold_instr", if_instr_o, 32'h13);
         chk("stall_hold_req", imem_req_o, 0);
      end
      chk("fetch0", qat(fetch_q, 0), 32'h0);
      chk("fetch1", qat(fetch_q, 1), 32'h4);
      chk("fetch2", qat(fetch_q, 2), 32'h8);
      chk("rate01", fetch_c.size() > 2 ? fetch_c[1] - fetch_c[0] : 0, 3);
      chk("rate12", fetch_c.size() > 2 ? fetch_c[2] - fetch_c[1] : 0, 3);
      chk("pc4_0", qat(pres_p4, 0), 32'h4);
      chk("pc4_1", qat(pres_p4, 1), 32'h8);
      chk("pc4_2", qat(pres_p4, 2), 32'hC);
      chk("instr_0", qat(pres_in, 0), 32'hA5A5_0000);
      if_ready_i = 1'b1;
      step();
      chk("after_accept_req", imem_req_o, 1);
      chk("after_accept_addr", imem_addr_o, 32'hC);
      // Redirect to 0x100 while the 0x10 response is still outstanding.
      wait_fetch(32'h10);
      clear_logs();
      rv_delay = 2;
      step();
      redirect_i = 1'b1; redirect_target_i = 32'h100;
      step();
      redirect_i = 1'b0; rv_delay = 0;
      wait_valid(32'h100);
      redirect_i = 1'b1; redirect_target_i = 32'h201;
      step();
      redirect_i = 1'b0;
      chk("killed_fetch_cnt", fetch_q.size(), 2);
      chk("redirect_fetch", qat(fetch_q, 1), 32'h100);
      chk("killed_pres_cnt", pres_pc.size(), 1);
      chk("killed_pres_pc", qat(pres_pc, 0), 32'h100);
      chk("jalr_no_mis", misaligned_o, 0);
      clear_logs();
      wait_valid(32'h200);
      chk("jalr_fetch", qat(fetch_q, 0), 32'h200);
      redirect_i = 1'b1; redirect_target_i = 32'h202;
      step();
      redirect_i = 1'b0;
      chk("mis_pulse", misaligned_o, 1);
      chk("mis_addr_pulse", misaligned_addr_o, 32'h202);
      step();
      chk("mis_one_cycle", misaligned_o, 0);
      chk("mis_addr_held", misaligned_addr_o, 32'h202);
      repeat (5) begin
         step();
         chk("mis_stalled_req", imem_req_o, 0);
      end
      redirect_i = 1'b1; redirect_target_i = 32'h400;
      step();
      redirect_i = 1'b0;
      chk("trap_req", imem_req_o, 1);
      chk("trap_addr", imem_addr_o, 32'h400);
      // Redirect and accept in the same HOLD cycle, then PC wrap.
      wait_valid(32'h400);
      redirect_i = 1'b1; redirect_target_i = 32'h20;
      step();
      redirect_i = 1'b0;
      wait_valid(32'h20);
      redirect_i = 1'b1; redirect_target_i = 32'h80;
      clear_logs();
      step();
      redirect_i = 1'b0;
      wait_valid(32'h80);
      chk("redir_wins_cnt", fetch_q.size(), 1);
      chk("redir_wins_addr", qat(fetch_q, 0), 32'h80);
      redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
      step();
      redirect_i = 1'b0;
      wait_valid(32'hFFFF_FFFC);
      chk("wrap_pc4", if_pc_plus4_o, 32'h0);
      clear_logs();
      wait_fetch(32'h0);
      step();
      chk("wrap_fetch", qat(fetch_q, 0), 32'h0);
      // Asynchronous reset while waiting on a response.
      rv_delay = 3;
      chk("pre_rst_wait_req", imem_req_o, 0);
      rst_ni = 1'b0;
      #1;
      chk("async_valid", if_valid_o, 0);
      chk("async_req", imem_req_o, 0);
      chk("async_pc", if_pc_o, 32'h0);
      chk("async_pc4", if_pc_plus4_o, 32'h4);
      chk("async_instr", if_instr_o, NOP);
      chk("async_mis", misaligned_o, 0);
      chk("async_mis_addr", misaligned_addr_o, 32'h0);
      repeat (2) @(posedge clk_i);
      #1;
      rv_delay = 0;
      rst_ni = 1'b1;
      step();
      chk("restart_req", imem_req_o, 1);
      chk("restart_addr", imem_addr_o, 32'h0);
      wait_valid(32'h0);
      chk("restart_instr", if_instr_o, 32'hA5A5_0000);
      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of decode/execute. Consumes the branch unit's taken decision plus the computed target, owns the program counter, and issues word fetches to the instruction-memory port. Presents one fetched instruction at a time to the IF/ID register over a valid/ready handshake. Squashes wrong-path instructions on redirect, including responses already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
NOP_INSTR, 32'h0000_0013, value driven on if_instr_o when no valid instruction is held (ADDI x0,x0,0).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
redirect_i  input  1  branch/jump taken (branch unit take output).
redirect_target_i  input  DATA_WIDTH  target address; bit 0 is ignored, JALR semantics.
imem_req_o  output  1  fetch request.
imem_addr_o  output  DATA_WIDTH  fetch address, word-aligned.
imem_gnt_i  input  1  request accepted this cycle.
imem_rvalid_i  input  1  response data valid.
imem_rdata_i  input  32  fetched instruction word.
if_valid_o  output  1  instruction valid toward decode.
if_ready_i  input  1  decode accepts this cycle.
if_pc_o  output  DATA_WIDTH  PC of the presented instruction.
if_pc_plus4_o  output  DATA_WIDTH  if_pc_o + 4, used for the JAL/JALR link value.
if_instr_o  output  32  presented instruction.
misaligned_o  output  1  one-cycle pulse: redirect target not 4-byte aligned.
misaligned_addr_o  output  DATA_WIDTH  offending target; held until the next pulse.

Behaviour:
- DATA_WIDTH comes from pkg_config (32).
- Reset (async assert, sync release) sets:
  - pc_q = RESET_PC; state IDLE; kill flag 0.
  - imem_req_o = 0; if_valid_o = 0; misaligned_o = 0.
  - if_pc_o = RESET_PC; if_pc_plus4_o = RESET_PC + 4; if_instr_o = NOP_INSTR; misaligned_addr_o = 0.
- Reset asserted mid-transaction abandons the transaction. The memory side is reset by the same rst_ni.
- States:
  - IDLE: imem_req_o = 0. Moves to REQ on the first cycle after reset release, or on a valid redirect.
  - REQ: imem_req_o = 1, imem_addr_o = pc_q. On imem_gnt_i, go to WAIT. The address may change without gnt; memory samples the address only on gnt.
  - WAIT: wait for imem_rvalid_i. At most one request is outstanding.
    - Kill flag set: discard the response, clear the kill flag, go to REQ.
    - Otherwise: latch if_instr_o = imem_rdata_i, if_pc_o = pc_q, if_pc_plus4_o = pc_q + 4; go to HOLD.
  - HOLD: if_valid_o = 1; outputs stable until the handshake. On if_valid_o & if_ready_i: pc_q += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0), if_valid_o = 0 next cycle, go to REQ.
- Latency:
  - Redirect or accept to imem_req_o = 1: next cycle.
  - rvalid to if_valid_o = 1: next cycle.
  - Zero-wait memory (gnt same cycle as req, rvalid one cycle later) gives one instruction per 3 cycles. No prefetch.
- Valid redirect (redirect_i & redirect_target_i[1] == 0), evaluated in any state:
  - pc_q = {redirect_target_i[DATA_WIDTH-1:2], 2'b00}.
  - if_valid_o = 0 next cycle; if_instr_o = NOP_INSTR.
  - Next state:
    - IDLE, REQ without gnt, HOLD -> REQ.
    - REQ with gnt in the same cycle -> WAIT with kill = 1.
    - WAIT without rvalid -> WAIT with kill = 1.
    - WAIT with rvalid in the same cycle -> REQ; the response is discarded.
  - Redirect wins over if_ready_i in the same cycle; pc_q is not incremented.
- Misaligned redirect (redirect_i & redirect_target_i[1] == 1):
  - misaligned_o = 1 for one cycle; misaligned_addr_o = redirect_target_i.
  - pc_q is unchanged; if_valid_o is flushed.
  - Next state is IDLE, or WAIT with kill = 1 if a request is in flight; the killed response then returns the unit to IDLE, not REQ.
  - Fetch stays stalled until the next valid redirect (the trap redirect).
- Outputs are registered except imem_req_o and imem_addr_o, which decode directly from state and pc_q.

Test Plan:
- Reset release with RESET_PC = 0x0, memory gnt immediate and rvalid one cycle later, if_ready_i = 1 -> addresses 0x0, 0x4, 0x8 fetched; if_pc_o/if_instr_o match memory; if_pc_plus4_o = 0x4, 0x8, 0xC; one instruction per 3 cycles.
- if_ready_i = 0 for 5 cycles while holding 0x0000_0013 at PC 0x8 -> outputs stable, imem_req_o = 0, then acceptance gives next request at 0xC.
- redirect_i with target 0x100 while in WAIT for PC 0x10 -> returned 0x10 word discarded (if_valid_o never 1 for it); next request at 0x100.
- redirect_i with target 0x201 (JALR, bit 0 set) -> fetch from 0x200, misaligned_o stays 0. Target 0x202 -> misaligned_o pulses 1 cycle, misaligned_addr_o = 0x202, no request until redirect to 0x400, then fetch at 0x400.
- Redirect and if_ready_i in the same cycle in HOLD (PC 0x20, target 0x80) -> next request at 0x80, not 0x24. Also check pc_q = 0xFFFF_FFFC accepted -> next fetch at 0x0.
- rst_ni asserted while in WAIT -> all outputs at reset values immediately (asynchronous); after release, fetch restarts at RESET_PC.
